// File: rtl/migration_packet_buffer.sv
// Store-and-forward AXI4-Stream packet buffer that holds whole packets during a live migration.
// Define PKT_DROP_EN to drop packets that do not fit (ingress never stalls) instead of back-pressuring.
module migration_packet_buffer #(
    parameter int AXIS_DATA_WIDTH  = 512,
    parameter int AXIS_TUSER_WIDTH = 256,
    parameter int DEPTH            = 1024,
    parameter int ADDR_WIDTH       = 10
) (
    input  logic                           axis_aclk,
    input  logic                           axis_resetn,
    input  logic [AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic [AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic [AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast,
    input  logic                           release_en,
    output logic                           empty,
    output logic [ADDR_WIDTH:0]            pkt_count,
    output logic [31:0]                    drop_count
);
    localparam int KEEP_W = AXIS_DATA_WIDTH / 8;
    localparam int WORD_W = 1 + AXIS_TUSER_WIDTH + KEEP_W + AXIS_DATA_WIDTH;
    localparam int PTR_W  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {WR_IDLE, WR_STORE, WR_DROP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

    wr_state_t wr_state_reg, wr_state_next;
    rd_state_t rd_state_reg, rd_state_next;

    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0] wr_cur_reg, wr_cur_next;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] pkt_count_reg, pkt_count_next;
    logic [PTR_W-1:0] used_beats;
    logic             empty_reg, empty_next;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [WORD_W-1:0] ram_q_reg;
    logic              ram_q_valid_reg;
    logic              ram_q_last;

    logic [WORD_W-1:0] out_word_reg, skid_word_reg;
    logic              out_valid_reg, out_valid_next;
    logic              skid_valid_reg, skid_valid_next;
    logic              rd_done_reg;

    logic       full, s_accept, drop_beat, wr_en, commit, abort;
    logic       rd_en, start_pkt, credit_ok, m_fire, m_fire_last;
    logic [1:0] pipe_fill;

    assign used_beats = wr_cur_reg - rd_ptr_reg;
    assign full       = (used_beats == PTR_W'(DEPTH));
    assign s_accept   = s_axis_tvalid & s_axis_tready;

`ifdef PKT_DROP_EN
    assign s_axis_tready = axis_resetn;
    assign drop_beat     = (wr_state_reg == WR_DROP) || full;
`else
    assign s_axis_tready = axis_resetn & ~full;
    assign drop_beat     = 1'b0;
`endif

    // Write FSM: state register
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            wr_state_reg <= WR_IDLE;
        end else begin
            wr_state_reg <= wr_state_next;
        end
    end

    // Write FSM: next state
    always_comb begin
        wr_state_next = wr_state_reg;
        case (wr_state_reg)
            WR_IDLE, WR_STORE, WR_DROP: begin
                if (s_accept) begin
                    if (s_axis_tlast) begin
                        wr_state_next = WR_IDLE;
                    end else if (drop_beat) begin
                        wr_state_next = WR_DROP;
                    end else begin
                        wr_state_next = WR_STORE;
                    end
                end
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    // Write FSM: outputs
    always_comb begin
        wr_en  = s_accept && !drop_beat;
        commit = wr_en && s_axis_tlast;
        abort  = s_accept && drop_beat && s_axis_tlast;
    end

    // Read side: a beat may be issued only if the skid pair can absorb it even if egress stalls.
    assign m_fire      = out_valid_reg & m_axis_tready;
    assign m_fire_last = m_fire & m_axis_tlast;
    assign ram_q_last  = ram_q_reg[WORD_W-1];
    assign start_pkt   = (pkt_count_reg != '0) && release_en;
    assign pipe_fill   = 2'(out_valid_reg) + 2'(skid_valid_reg) + 2'(ram_q_valid_reg);
    assign credit_ok   = (pipe_fill - 2'(m_fire)) <= 2'd1;

    // Read FSM: state register
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            rd_state_reg <= RD_IDLE;
        end else begin
            rd_state_reg <= rd_state_next;
        end
    end

    // Read FSM: next state
    always_comb begin
        rd_state_next = rd_state_reg;
        if (rd_state_reg == RD_IDLE) begin
            if (start_pkt) begin
                rd_state_next = RD_SEND;
            end
        end else if (m_fire_last) begin
            rd_state_next = RD_IDLE;
        end
    end

    // Read FSM: outputs. The tlast of the word just read stops further reads, so the
    // next packet is never prefetched past its release gate.
    always_comb begin
        rd_en = 1'b0;
        if (rd_state_reg == RD_IDLE) begin
            rd_en = start_pkt;
        end else begin
            rd_en = !rd_done_reg && !(ram_q_valid_reg && ram_q_last) && credit_ok
                    && (rd_ptr_reg != wr_ptr_reg);
        end
    end

    // Pointer and counter next-state
    always_comb begin
        wr_cur_next = wr_cur_reg;
        if (abort) begin
            wr_cur_next = wr_ptr_reg;
        end else if (wr_en) begin
            wr_cur_next = wr_cur_reg + PTR_W'(1);
        end
        wr_ptr_next = commit ? (wr_cur_reg + PTR_W'(1)) : wr_ptr_reg;
        rd_ptr_next = rd_en ? (rd_ptr_reg + PTR_W'(1)) : rd_ptr_reg;
        case ({commit, m_fire_last})
            2'b10:   pkt_count_next = pkt_count_reg + PTR_W'(1);
            2'b01:   pkt_count_next = pkt_count_reg - PTR_W'(1);
            default: pkt_count_next = pkt_count_reg;
        endcase
    end

    // Two-entry output pipeline: out_word is the head, skid_word the second entry.
    always_comb begin
        out_valid_next  = skid_valid_reg | ram_q_valid_reg | (out_valid_reg & ~m_fire);
        skid_valid_next = (out_valid_reg & ~m_fire & ram_q_valid_reg)
                        | (skid_valid_reg & ~m_fire)
                        | (skid_valid_reg & m_fire & ram_q_valid_reg);
        empty_next      = (wr_cur_next == rd_ptr_next) && !rd_en && !out_valid_next
                        && (wr_state_next == WR_IDLE);
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            wr_ptr_reg      <= '0;
            wr_cur_reg      <= '0;
            rd_ptr_reg      <= '0;
            pkt_count_reg   <= '0;
            empty_reg       <= 1'b1;
            ram_q_valid_reg <= 1'b0;
            rd_done_reg     <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            wr_cur_reg      <= wr_cur_next;
            rd_ptr_reg      <= rd_ptr_next;
            pkt_count_reg   <= pkt_count_next;
            empty_reg       <= empty_next;
            ram_q_valid_reg <= rd_en;
            if (rd_state_reg == RD_IDLE) begin
                rd_done_reg <= 1'b0;
            end else if (ram_q_valid_reg && ram_q_last) begin
                rd_done_reg <= 1'b1;
            end
        end
    end

    // Packet RAM with registered read
    always_ff @(posedge axis_aclk) begin
        if (wr_en) begin
            mem[wr_cur_reg[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
        end
        if (rd_en) begin
            ram_q_reg <= mem[rd_ptr_reg[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            out_word_reg   <= '0;
            skid_word_reg  <= '0;
        end else begin
            out_valid_reg  <= out_valid_next;
            skid_valid_reg <= skid_valid_next;
            if (m_fire && skid_valid_reg) begin
                out_word_reg <= skid_word_reg;
            end else if (ram_q_valid_reg && (!out_valid_reg || m_fire)) begin
                out_word_reg <= ram_q_reg;
            end
            if (ram_q_valid_reg && ((out_valid_reg && !m_fire && !skid_valid_reg)
                                    || (skid_valid_reg && m_fire))) begin
                skid_word_reg <= ram_q_reg;
            end
        end
    end

`ifdef PKT_DROP_EN
    logic [31:0] drop_count_reg;

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            drop_count_reg <= '0;
        end else if (abort && (drop_count_reg != '1)) begin
            drop_count_reg <= drop_count_reg + 32'd1;
        end
    end

    assign drop_count = drop_count_reg;
`else
    assign drop_count = 32'd0;
`endif

    assign m_axis_tvalid = out_valid_reg;
    assign m_axis_tdata  = out_word_reg[AXIS_DATA_WIDTH-1:0];
    assign m_axis_tkeep  = out_word_reg[AXIS_DATA_WIDTH +: KEEP_W];
    assign m_axis_tuser  = out_word_reg[AXIS_DATA_WIDTH+KEEP_W +: AXIS_TUSER_WIDTH];
    assign m_axis_tlast  = out_word_reg[WORD_W-1];
    assign pkt_count     = pkt_count_reg;
    assign empty         = empty_reg;

endmodule

// File: tb/tb_migration_packet_buffer.sv
// Directed bench for migration_packet_buffer with DEPTH=16 and narrow data: hold/release, latency,
// streaming, backpressure-and-wrap (or drop when PKT_DROP_EN), mid-packet release, async reset.
`timescale 1ns/1ps
module tb_migration_packet_buffer;
    localparam int DW    = 32;
    localparam int UW    = 8;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid, s_tready, s_tlast;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid, m_tready, m_tlast;
    logic          release_en, empty;
    logic [AW:0]   pkt_count;
    logic [31:0]   drop_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    migration_packet_buffer #(
        .AXIS_DATA_WIDTH (DW),
        .AXIS_TUSER_WIDTH(UW),
        .DEPTH           (DEPTH),
        .ADDR_WIDTH      (AW)
    ) dut (
        .axis_aclk    (clk),
        .axis_resetn  (rst_n),
        .s_axis_tdata (s_tdata),
        .s_axis_tkeep (s_tkeep),
        .s_axis_tuser (s_tuser),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .s_axis_tlast (s_tlast),
        .m_axis_tdata (m_tdata),
        .m_axis_tkeep (m_tkeep),
        .m_axis_tuser (m_tuser),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .release_en   (release_en),
        .empty        (empty),
        .pkt_count    (pkt_count),
        .drop_count   (drop_count)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
        int            exp_pkts;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired, required the DUT event", name);
    endtask

    // Called at a negedge; returns at the negedge after the handshake edge.
    task automatic send_beat(input logic [DW-1:0] d, input logic [UW-1:0] u,
                             input logic [KW-1:0] k, input logic l);
        int n;
        n = 0;
        s_tdata = d; s_tuser = u; s_tkeep = k; s_tlast = l; s_tvalid = 1'b1;
        while (!s_tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) timeout_fail("send_timeout");
        @(negedge clk);
        s_tvalid = 1'b0;
        $display("tx data=0x%0h user=0x%0h keep=0x%0h last=%0d", d, u, k, l);
    endtask

    task automatic send_pkt(input int base, input int len);
        for (int i = 0; i < len; i++) begin
            send_beat(32'(base + i), 8'(base), 4'hF, i == len - 1);
        end
    endtask

    task automatic recv_beat(output logic [DW-1:0] d, output logic [UW-1:0] u,
                             output logic [KW-1:0] k, output logic l);
        int n;
        n = 0;
        m_tready = 1'b1;
        while (!m_tvalid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!m_tvalid) timeout_fail("recv_timeout");
        d = m_tdata; u = m_tuser; k = m_tkeep; l = m_tlast;
        $display("rx data=0x%0h user=0x%0h keep=0x%0h last=%0d", d, u, k, l);
        @(negedge clk);
    endtask

    task automatic recv_expect(input string name, input int exp_data, input logic exp_last);
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        logic          l;
        recv_beat(d, u, k, l);
        check({name, "_data"}, d, 32'(exp_data));
        check({name, "_last"}, 32'(l), 32'(exp_last));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        logic          l;
        int            got, bubbles, n;
        logic          in_pkt, stalled;

        vecs[0] = '{32'hA000_0001, 8'h11, 4'hF, 1'b1, 1};
        vecs[1] = '{32'hB000_0001, 8'h22, 4'hF, 1'b0, 1};
        vecs[2] = '{32'hB000_0002, 8'h23, 4'h3, 1'b0, 1};
        vecs[3] = '{32'hB000_0003, 8'h24, 4'h1, 1'b1, 2};
        vecs[4] = '{32'hC000_0001, 8'h35, 4'hF, 1'b0, 2};
        vecs[5] = '{32'hC000_0002, 8'h36, 4'h7, 1'b1, 3};
        vecs[6] = '{32'hD000_0001, 8'h4A, 4'h8, 1'b1, 4};

        rst_n = 1'b0; release_en = 1'b0; m_tready = 1'b0;
        s_tvalid = 1'b0; s_tdata = '0; s_tuser = '0; s_tkeep = '0; s_tlast = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tlast", 32'(m_tlast), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_pkt_count", 32'(pkt_count), 32'd0);
        check("rst_drop_count", drop_count, 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_tready", 32'(s_tready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("tready_after_rst", 32'(s_tready), 32'd1);

        // Single 3-beat packet held, then released
        send_pkt(1, 3);
        check("hold_pkt_count", 32'(pkt_count), 32'd1);
        check("hold_empty", 32'(empty), 32'd0);
        repeat (3) @(negedge clk);
        check("hold_tvalid", 32'(m_tvalid), 32'd0);
        release_en = 1'b1;
        for (int i = 0; i < 3; i++) recv_expect("single", 1 + i, i == 2);
        m_tready = 1'b0;
        check("single_pkt_count", 32'(pkt_count), 32'd0);
        @(negedge clk);
        check("single_empty", 32'(empty), 32'd1);
        release_en = 1'b0;

        // Table: mixed packets with distinct tuser/tkeep stored while held, then released
        for (int i = 0; i < 7; i++) begin
            send_beat(vecs[i].data, vecs[i].user, vecs[i].keep, vecs[i].last);
            check("tbl_pkt_count", 32'(pkt_count), 32'(vecs[i].exp_pkts));
            check("tbl_held_tvalid", 32'(m_tvalid), 32'd0);
        end
        release_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            recv_beat(d, u, k, l);
            check("tbl_data", d, vecs[i].data);
            check("tbl_user", 32'(u), 32'(vecs[i].user));
            check("tbl_keep", 32'(k), 32'(vecs[i].keep));
            check("tbl_last", 32'(l), 32'(vecs[i].last));
        end
        m_tready = 1'b0;
        check("tbl_pkt_count_end", 32'(pkt_count), 32'd0);
        check("tbl_empty_end", 32'(empty), 32'd1);

        // Latency: tlast accepted at edge N, tvalid visible after edge N+2
        m_tready = 1'b1;
        send_beat(32'h55, 8'h5, 4'hF, 1'b1);
        check("lat_n0_tvalid", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        check("lat_n1_tvalid", 32'(m_tvalid), 32'd0);
        @(negedge clk);
        check("lat_n2_tvalid", 32'(m_tvalid), 32'd1);
        check("lat_n2_data", m_tdata, 32'h55);
        @(negedge clk);
        check("lat_after_tvalid", 32'(m_tvalid), 32'd0);

        // Streaming: 10 back-to-back 4-beat packets, no bubbles inside a packet
        got = 0; bubbles = 0; n = 0; in_pkt = 1'b0;
        fork
            begin
                for (int p = 0; p < 10; p++) send_pkt(1000 + p * 4, 4);
            end
            begin
                while (got < 40 && n < 1000) begin
                    if (m_tvalid) begin
                        check("stream_data", m_tdata, 32'(1000 + got));
                        check("stream_last", 32'(m_tlast), 32'((got % 4) == 3));
                        in_pkt = !m_tlast;
                        got++;
                    end else if (in_pkt) begin
                        bubbles++;
                    end
                    @(negedge clk);
                    n++;
                end
            end
        join
        if (got < 40) timeout_fail("stream_timeout");
        check("stream_bubbles", 32'(bubbles), 32'd0);
        check("stream_pkt_count", 32'(pkt_count), 32'd0);
        release_en = 1'b0;
        m_tready = 1'b0;

`ifdef PKT_DROP_EN
        // Drop: 12-beat packet fits, following 8-beat packet overflows and is discarded
        send_pkt(300, 12);
        send_pkt(400, 8);
        check("drop_count", drop_count, 32'd1);
        check("drop_pkt_count", 32'(pkt_count), 32'd1);
        check("drop_empty", 32'(empty), 32'd0);
        release_en = 1'b1;
        for (int i = 0; i < 12; i++) recv_expect("drop_keep", 300 + i, i == 11);
        repeat (5) @(negedge clk);
        check("drop_no_extra", 32'(m_tvalid), 32'd0);
        check("drop_empty_end", 32'(empty), 32'd1);
        m_tready = 1'b0;
        release_en = 1'b0;
`else
        // Backpressure and wrap: fill all 16 beats, then drain with random tready
        send_pkt(200, 16);
        check("full_tready", 32'(s_tready), 32'd0);
        check("full_pkt_count", 32'(pkt_count), 32'd1);
        release_en = 1'b1;
        got = 0; n = 0; stalled = 1'b0;
        while (got < 16 && n < 2000) begin
            if (stalled) check("stall_hold_tvalid", 32'(m_tvalid), 32'd1);
            if (m_tvalid) begin
                check("wrap_data", m_tdata, 32'(200 + got));
                check("wrap_last", 32'(m_tlast), 32'(got == 15));
            end
            m_tready = 1'($urandom_range(0, 1));
            stalled = m_tvalid && !m_tready;
            if (m_tvalid && m_tready) got++;
            @(negedge clk);
            n++;
        end
        if (got < 16) timeout_fail("wrap_timeout");
        m_tready = 1'b0;
        release_en = 1'b0;
        check("wrap_tready", 32'(s_tready), 32'd1);
        check("wrap_empty", 32'(empty), 32'd1);
`endif

        // Release dropped mid-packet: packet completes, next one waits
        send_pkt(500, 5);
        send_pkt(600, 2);
        release_en = 1'b1;
        recv_expect("mid", 500, 1'b0);
        release_en = 1'b0;
        for (int i = 1; i < 5; i++) recv_expect("mid", 500 + i, i == 4);
        repeat (6) @(negedge clk);
        check("mid_wait_tvalid", 32'(m_tvalid), 32'd0);
        check("mid_wait_pkt_count", 32'(pkt_count), 32'd1);
        release_en = 1'b1;
        recv_expect("mid_next", 600, 1'b0);
        recv_expect("mid_next", 601, 1'b1);
        m_tready = 1'b0;
        release_en = 1'b0;

        // Async reset with one packet partially sent and two stored
        send_pkt(700, 4);
        send_pkt(710, 2);
        send_pkt(720, 2);
        release_en = 1'b1;
        recv_expect("pre_rst", 700, 1'b0);
        recv_expect("pre_rst", 701, 1'b0);
        m_tready = 1'b0;
        release_en = 1'b0;
        check("pre_rst_pkt_count", 32'(pkt_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", 32'(m_tvalid), 32'd0);
        check("arst_pkt_count", 32'(pkt_count), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_drop_count", drop_count, 32'd0);
        check("arst_tready", 32'(s_tready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        release_en = 1'b1;
        send_pkt(800, 2);
        recv_expect("post_rst", 800, 1'b0);
        recv_expect("post_rst", 801, 1'b1);
        m_tready = 1'b0;
        check("post_rst_pkt_count", 32'(pkt_count), 32'd0);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
